// File: rtl/test_adc_source.sv
// test_adc_source
// Replays a stored waveform into the filter-side ADC input. A small pattern
// RAM is loaded through a write port. Each playback walks addresses
// 0..pat_len on every sample strobe. Playbacks can repeat a set number of
// times or forever, with an optional run of baseline samples between them.
module test_adc_source #(
  parameter int SIZE_ADC_DATA      = 14,
  parameter int SIZE_TEST_RAM_ADDR = 7,
  parameter int SIZE_TEST_COUNTER  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [SIZE_TEST_RAM_ADDR-1:0] wr_addr,
  input  logic [SIZE_ADC_DATA-1:0]      wr_data,
  input  logic                          start,
  input  logic                          stop,
  input  logic [SIZE_TEST_RAM_ADDR-1:0] pat_len,
  input  logic [SIZE_TEST_COUNTER-1:0]  repeat_cnt,
  input  logic [SIZE_TEST_COUNTER-1:0]  gap_len,
  input  logic [SIZE_ADC_DATA-1:0]      baseline,
  input  logic                          sample_en,
  output logic [SIZE_ADC_DATA-1:0]      adc_data,
  output logic                          adc_valid,
  output logic                          busy,
  output logic                          done,
  output logic [SIZE_TEST_COUNTER-1:0]  play_cnt
);

  localparam int DEPTH = 1 << SIZE_TEST_RAM_ADDR;
  localparam logic [SIZE_TEST_COUNTER-1:0]  CNT_ONE  = SIZE_TEST_COUNTER'(1);
  localparam logic [SIZE_TEST_COUNTER-1:0]  CNT_ZERO = SIZE_TEST_COUNTER'(0);
  localparam logic [SIZE_TEST_RAM_ADDR-1:0] ADDR_ONE = SIZE_TEST_RAM_ADDR'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [SIZE_ADC_DATA-1:0]      mem_r [DEPTH];
  logic [SIZE_TEST_RAM_ADDR-1:0] addr_r;
  logic [SIZE_TEST_RAM_ADDR-1:0] pat_len_r;
  logic [SIZE_TEST_COUNTER-1:0]  rep_r;
  logic [SIZE_TEST_COUNTER-1:0]  gap_len_r;
  logic [SIZE_TEST_COUNTER-1:0]  gap_cnt_r;
  logic [SIZE_TEST_COUNTER-1:0]  play_cnt_r;
  logic [SIZE_ADC_DATA-1:0]      adc_data_r;
  logic                          adc_valid_r;
  logic                          busy_r;
  logic                          done_r;

  logic                          start_ok_s;
  logic                          play_step_s;
  logic                          gap_step_s;
  logic                          last_s;
  logic                          finish_s;
  logic [SIZE_TEST_COUNTER-1:0]  play_inc_s;
  logic [SIZE_ADC_DATA-1:0]      adc_data_nxt_s;
  logic                          busy_nxt_s;
  logic                          done_nxt_s;

  // A start is accepted only from IDLE, and a simultaneous stop overrides it.
  // The last-address strobe in PLAY is the only point where a playback can
  // complete.
  always_comb begin
    start_ok_s  = (state_r == ST_IDLE) && start && !stop;
    play_step_s = (state_r == ST_PLAY) && sample_en && !stop;
    gap_step_s  = (state_r == ST_GAP) && sample_en && !stop;
    last_s      = play_step_s && (addr_r == pat_len_r);
    play_inc_s  = play_cnt_r + CNT_ONE;
    finish_s    = last_s && (rep_r != CNT_ZERO) && (play_inc_s == rep_r);
  end

  // Pattern RAM write port. The RAM has no reset, so its contents survive a
  // reset. A read of the same address in the same cycle sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode. stop returns to IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s) begin
          if (finish_s) begin
            state_nxt_s = ST_IDLE;
          end else if (gap_len_r == CNT_ZERO) begin
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_GAP;
          end
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (gap_step_s && (gap_cnt_r <= CNT_ONE)) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode. Each strobe emits a pattern word in PLAY and the live
  // baseline elsewhere; with no strobe the last sample is held.
  always_comb begin
    adc_data_nxt_s = adc_data_r;
    if (sample_en) begin
      if (state_r == ST_PLAY) begin
        adc_data_nxt_s = mem_r[addr_r];
      end else begin
        adc_data_nxt_s = baseline;
      end
    end else begin
      adc_data_nxt_s = adc_data_r;
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = finish_s;
  end

  // Registered outputs, playback address, counters and the configuration
  // latched at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= '0;
      pat_len_r   <= '0;
      rep_r       <= '0;
      gap_len_r   <= '0;
      gap_cnt_r   <= '0;
      play_cnt_r  <= '0;
      adc_data_r  <= '0;
      adc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      adc_data_r  <= adc_data_nxt_s;
      adc_valid_r <= sample_en;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      if (start_ok_s) begin
        pat_len_r  <= pat_len;
        rep_r      <= repeat_cnt;
        gap_len_r  <= gap_len;
        addr_r     <= '0;
        play_cnt_r <= '0;
      end else if (play_step_s) begin
        if (last_s) begin
          addr_r     <= '0;
          play_cnt_r <= play_inc_s;
          gap_cnt_r  <= gap_len_r;
        end else begin
          addr_r <= addr_r + ADDR_ONE;
        end
      end else if (gap_step_s) begin
        gap_cnt_r <= gap_cnt_r - CNT_ONE;
      end
    end
  end

  assign adc_data  = adc_data_r;
  assign adc_valid = adc_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign play_cnt  = play_cnt_r;

endmodule

// File: tb/tb_test_adc_source.sv
// Directed bench for test_adc_source. It loads patterns, runs the playback
// scenarios and compares the emitted sample stream with hand-built expected
// sequences.
module tb_test_adc_source;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [13:0] wr_data;
  logic        start;
  logic        stop;
  logic [6:0]  pat_len;
  logic [15:0] repeat_cnt;
  logic [15:0] gap_len;
  logic [13:0] baseline;
  logic        sample_en;
  logic [13:0] adc_data;
  logic        adc_valid;
  logic        busy;
  logic        done;
  logic [15:0] play_cnt;

  int n_tests;
  int n_fail;
  int done_seen;
  logic [13:0] exp_q[$];

  test_adc_source #(
    .SIZE_ADC_DATA(14),
    .SIZE_TEST_RAM_ADDR(7),
    .SIZE_TEST_COUNTER(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .stop(stop), .pat_len(pat_len),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .baseline(baseline),
    .sample_en(sample_en), .adc_data(adc_data), .adc_valid(adc_valid),
    .busy(busy), .done(done), .play_cnt(play_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = 14'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 32'(adc_data), 32'd0);
    check({tag, "_valid"}, 32'(adc_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pcnt"}, 32'(play_cnt), 32'd0);
  endtask

  // Start a playback, strobe every 'period' cycles, collect the samples and
  // compare them with exp_q.
  task automatic play(input string tag, input int period, input int budget);
    logic [13:0] obs_q[$];
    logic se;
    int cyc;
    done_seen = 0;
    start = 1'b1; stop = 1'b0; sample_en = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < budget) begin
      se = ((cyc % period) == 0);
      sample_en = se;
      tick();
      check({tag, "_valid"}, 32'(adc_valid), 32'(se));
      if (done) done_seen++;
      if (adc_valid) obs_q.push_back(adc_data);
      cyc++;
    end
    sample_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done) done_seen++;
    end
    check({tag, "_budget"}, 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < obs_q.size())
        check($sformatf("%s_s%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; done_seen = 0;
    reset_n = 1'b0; wr_en = 1'b0; wr_addr = 7'd0; wr_data = 14'd0;
    start = 1'b0; stop = 1'b0; pat_len = 7'd0; repeat_cnt = 16'd0;
    gap_len = 16'd0; baseline = 14'd0; sample_en = 1'b0;
    tick(); tick();
    check_zero("rst");
    reset_n = 1'b1;
    tick();

    // Four-word pattern, two playbacks, two-sample gap, continuous strobes.
    wr(0, 100); wr(1, 200); wr(2, 300); wr(3, 400);
    pat_len = 7'd3; repeat_cnt = 16'd2; gap_len = 16'd2; baseline = 14'd50;
    exp_q = '{14'd100, 14'd200, 14'd300, 14'd400, 14'd50, 14'd50,
              14'd100, 14'd200, 14'd300, 14'd400, 14'd50};
    play("t1", 1, 40);
    check("t1_done", 32'(done_seen), 32'd1);
    check("t1_pcnt", 32'(play_cnt), 32'd2);
    check("t1_busy", 32'(busy), 32'd0);

    // Same setup with a strobe every third cycle gives the same values.
    play("t2", 3, 80);
    check("t2_done", 32'(done_seen), 32'd1);
    check("t2_pcnt", 32'(play_cnt), 32'd2);
    check("t2_busy", 32'(busy), 32'd0);

    // Continuous mode, stopped after the second sample.
    repeat_cnt = 16'd0;
    start = 1'b1; sample_en = 1'b0;
    tick();
    start = 1'b0;
    check("t3_busy_on", 32'(busy), 32'd1);
    sample_en = 1'b1;
    tick();
    check("t3_s0", 32'(adc_data), 32'd100);
    check("t3_done0", 32'(done), 32'd0);
    tick();
    check("t3_s1", 32'(adc_data), 32'd200);
    check("t3_done1", 32'(done), 32'd0);
    stop = 1'b1; sample_en = 1'b0;
    tick();
    stop = 1'b0;
    check("t3_busy_off", 32'(busy), 32'd0);
    check("t3_done2", 32'(done), 32'd0);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    check("t3_base", 32'(adc_data), 32'd50);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done3", 32'(done), 32'd0);
    check("t3_pcnt", 32'(play_cnt), 32'd0);

    // start and stop together in IDLE: stop wins.
    baseline = 14'd77;
    start = 1'b1; stop = 1'b1; sample_en = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; sample_en = 1'b0;
    check("t4_busy0", 32'(busy), 32'd0);
    check("t4_base", 32'(adc_data), 32'd77);
    tick();
    check("t4_busy1", 32'(busy), 32'd0);

    // Full 128-entry pattern, no gap, three playbacks back to back.
    for (int i = 0; i < 128; i++) wr(i, i * 3 + 1);
    baseline = 14'd50; pat_len = 7'd127; repeat_cnt = 16'd3; gap_len = 16'd0;
    exp_q.delete();
    for (int k = 0; k < 384; k++) exp_q.push_back(14'((k % 128) * 3 + 1));
    exp_q.push_back(14'd50);
    play("t5", 1, 500);
    check("t5_done", 32'(done_seen), 32'd1);
    check("t5_pcnt", 32'(play_cnt), 32'd3);
    check("t5_busy", 32'(busy), 32'd0);

    // Reset mid-playback, then replay the retained pattern.
    pat_len = 7'd1; repeat_cnt = 16'd0; gap_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0; sample_en = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t6_pcnt_pre", 32'(play_cnt), 32'd2);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_zero("t6_rst");
    sample_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_busy_post", 32'(busy), 32'd0);
    pat_len = 7'd3; repeat_cnt = 16'd1; gap_len = 16'd0;
    exp_q = '{14'd1, 14'd4, 14'd7, 14'd10, 14'd50};
    play("t6", 1, 20);
    check("t6_done", 32'(done_seen), 32'd1);
    check("t6_pcnt", 32'(play_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_adc_source.md
TEST_ADC_SOURCE -- requirements
Module: test_adc_source

Interface
REQ-001 SHALL have parameter SIZE_ADC_DATA, default 14: width of the emitted ADC sample and of the pattern words.
REQ-002 SHALL have parameter SIZE_TEST_RAM_ADDR, default 7: pattern memory address width, giving 128 entries.
REQ-003 SHALL have parameter SIZE_TEST_COUNTER, default 16: width of the repeat, gap and play counters.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock, all state on its rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  pattern memory write strobe.
REQ-007 wr_addr  in  SIZE_TEST_RAM_ADDR  pattern write address.
REQ-008 wr_data  in  SIZE_ADC_DATA  pattern write word.
REQ-009 start  in  1  one-cycle playback request.
REQ-010 stop  in  1  one-cycle abort request.
REQ-011 pat_len  in  SIZE_TEST_RAM_ADDR  last pattern address played (length = pat_len+1).
REQ-012 repeat_cnt  in  SIZE_TEST_COUNTER  number of playbacks; 0 = continuous.
REQ-013 gap_len  in  SIZE_TEST_COUNTER  baseline samples between playbacks.
REQ-014 baseline  in  SIZE_ADC_DATA  sample value outside playback.
REQ-015 sample_en  in  1  ADC sample strobe; 1 = one sample this cycle.
REQ-016 adc_data  out  SIZE_ADC_DATA  emitted sample (filter-side ADC input).
REQ-017 adc_valid  out  1  adc_data holds a new sample.
REQ-018 busy  out  1  state is not IDLE.
REQ-019 done  out  1  one-cycle pulse on normal completion.
REQ-020 play_cnt  out  SIZE_TEST_COUNTER  completed playbacks since last start.

Function
REQ-021 Pattern memory: 128 x SIZE_ADC_DATA, not reset, written when wr_en=1 in any state; contents persist through reset.
REQ-022 On a same-cycle write and read of one address, the read SHALL return the old word.
REQ-023 States SHALL be IDLE, PLAY and GAP.
REQ-024 adc_valid SHALL equal sample_en delayed by one clock, in every state.
REQ-025 On each sample_en cycle: in PLAY adc_data <= pattern[addr]; in IDLE or GAP adc_data <= live baseline. Otherwise adc_data holds.
REQ-026 IDLE with start=1 and stop=0 SHALL:
- latch pat_len, repeat_cnt and gap_len;
- clear addr and play_cnt;
- enter PLAY next cycle.
REQ-027 start while busy SHALL be ignored.
REQ-028 PLAY on sample_en with addr<pat_len SHALL increment addr.
REQ-029 PLAY on sample_en with addr=pat_len SHALL:
- set addr to 0 and increment play_cnt;
- then, if latched repeat_cnt≠0 and play_cnt+1=repeat_cnt, go to IDLE and pulse done next cycle;
- else if gap_len=0, stay in PLAY (back-to-back);
- else go to GAP with gap counter = gap_len.
REQ-030 GAP SHALL decrement the gap counter on each sample_en and return to PLAY on the sample_en where it equals 1, giving exactly gap_len baseline samples.
REQ-031 With sample_en=0 the FSM SHALL make no progress and hold addr and counters.
REQ-032 stop=1 in any state SHALL force IDLE next cycle, with no done pulse and play_cnt held; stop wins over a simultaneous start.
REQ-033 In continuous mode play_cnt SHALL wrap from 2^SIZE_TEST_COUNTER-1 to 0.
REQ-034 busy SHALL be registered, asserted from the cycle after an accepted start until the cycle IDLE is entered.

Reset
REQ-035 reset_n=0 SHALL asynchronously set state to IDLE, and addr, gap counter, play_cnt, adc_data, adc_valid, busy and done to 0.
REQ-036 Reset released mid-operation SHALL resume in IDLE; a new start SHALL replay the retained pattern.

Verification
REQ-037 Pattern {100,200,300,400}, pat_len=3, repeat=2, gap=2, baseline=50, sample_en=1, start -> adc_data 100,200,300,400,50,50,100,200,300,400, then 50; one done pulse; play_cnt=2; busy low after.
REQ-038 Same setup with sample_en high every 3rd cycle -> identical value sequence; adc_valid high only the cycle after each strobe.
REQ-039 repeat=0, stop after the 2nd sample of a playback -> next sample = baseline, busy=0, done never asserted.
REQ-040 start and stop in the same IDLE cycle -> busy stays 0, adc_data = baseline.
REQ-041 pat_len=127, gap=0, repeat=3 -> address sequence 126,127,0,1 with no baseline sample between; 384 pattern samples; done once.
REQ-042 reset_n low mid-PLAY -> all outputs 0 immediately; after release, start replays the unchanged pattern from address 0.
